// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - instruction decode stage with a 2-entry skid buffer
module decode_ctrl #(
  parameter int XLEN   = 32,
  parameter int OP_LEN = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_types,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [7:0]      illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      types;
    logic            illegal;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          sec_q, sec_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [OP_LEN-1:0] opcode;
  logic [6:0]        dec_types;
  logic              dec_illegal;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   dec_imm;
  entry_t            in_entry;
  logic              push, pop;

  // Decode the incoming instruction so the entry is stored fully decoded
  always_comb begin
    dec_types   = 7'b0;
    dec_illegal = 1'b0;
    imm32       = 32'b0;
    opcode      = in_instr[OP_LEN-1:0];
    case (opcode)
      7'b0110011: dec_types = 7'b1000000;
      7'b0010011, 7'b1100111: begin
        dec_types = 7'b0100000;
        // shift-immediate forms carry only a 5-bit unsigned shamt
        if (in_instr[13:12] == 2'b01) imm32 = {27'b0, in_instr[24:20]};
        else                          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0000011: begin
        dec_types = 7'b0010000;
        imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_types = 7'b0001000;
        imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_types = 7'b0000100;
        imm32     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_types = 7'b0000010;
        imm32     = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_types = 7'b0000001;
        imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0001111, 7'b1110011: dec_types = 7'b0;
      default:                dec_illegal = 1'b1;
    endcase
    dec_imm        = {XLEN{imm32[31]}};
    dec_imm[31:0]  = imm32;
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Payload is forced to zero whenever the head is not valid
  assign out_instr   = out_valid ? head_q.instr         : '0;
  assign out_pc      = out_valid ? head_q.pc            : '0;
  assign out_imm     = out_valid ? head_q.imm           : '0;
  assign out_types   = out_valid ? head_q.types         : 7'b0;
  assign out_funct3  = out_valid ? head_q.instr[14:12]  : 3'b0;
  assign out_illegal = out_valid ? head_q.illegal       : 1'b0;
  assign illegal_cnt = cnt_q;

  // Next-state, buffer movement and illegal counter; flush overrides everything
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    sec_d    = sec_q;
    cnt_d    = cnt_q;
    in_entry = '{instr: in_instr, pc: in_pc, imm: dec_imm,
                 types: dec_types, illegal: dec_illegal};
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (push && dec_illegal && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
      case (state_q)
        EMPTY: if (push) begin
          head_d  = in_entry;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            sec_d   = in_entry;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          head_d  = sec_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      sec_q   <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb/tb_decode_ctrl.sv - self-checking bench for decode_ctrl
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
  logic [6:0]  out_types;
  logic [2:0]  out_funct3;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  int checks = 0;
  int errors = 0;

  decode_ctrl #(.XLEN(32), .OP_LEN(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_types(out_types), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  types;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        ill;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 7'h20, 32'h00000005, 3'd0, 1'b0};
    vecs[1]  = '{32'hFE010FA3, 7'h08, 32'hFFFFFFFF, 3'd0, 1'b0};
    vecs[2]  = '{32'h0000006F, 7'h01, 32'h00000000, 3'd0, 1'b0};
    vecs[3]  = '{32'h00105013, 7'h20, 32'h00000001, 3'd5, 1'b0};
    vecs[4]  = '{32'h123450B7, 7'h02, 32'h12345000, 3'd5, 1'b0};
    vecs[5]  = '{32'h00208033, 7'h40, 32'h00000000, 3'd0, 1'b0};
    vecs[6]  = '{32'hFFC4A303, 7'h10, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[7]  = '{32'h00000463, 7'h04, 32'h00000008, 3'd0, 1'b0};
    vecs[8]  = '{32'h80000063, 7'h04, 32'hFFFFF000, 3'd0, 1'b0};
    vecs[9]  = '{32'h8000006F, 7'h01, 32'hFFF00000, 3'd0, 1'b0};
    vecs[10] = '{32'h00001017, 7'h02, 32'h00001000, 3'd1, 1'b0};
    vecs[11] = '{32'h0000000F, 7'h00, 32'h00000000, 3'd0, 1'b0};
    vecs[12] = '{32'h00000073, 7'h00, 32'h00000000, 3'd0, 1'b0};
    vecs[13] = '{32'h0000007F, 7'h00, 32'h00000000, 3'd0, 1'b1};
    vecs[14] = '{32'h00000010, 7'h00, 32'h00000000, 3'd0, 1'b1};
    vecs[15] = '{32'hFFF09093, 7'h20, 32'h0000001F, 3'd1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // table: push one entry, check decoded head, then drain it
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h100 + 32'(4 * i);
      cyc();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_types", i), out_types, vecs[i].types);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_funct3", i), out_funct3, vecs[i].f3);
      chk($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h100 + 32'(4 * i));
      chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
      in_valid = 1'b0;
      cyc();
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end
    chk("table_illegal_cnt", illegal_cnt, 2);

    // fill both entries with downstream stalled, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE010FA3; in_pc = 32'h400;
    cyc();
    in_instr = 32'h0000006F; in_pc = 32'h404;
    cyc();
    chk("two_in_ready", in_ready, 0);
    chk("two_types", out_types, 7'h08);
    chk("two_imm", out_imm, 32'hFFFFFFFF);
    in_instr = 32'h00500093; in_pc = 32'h408;
    cyc();
    chk("two_hold_types", out_types, 7'h08);
    chk("two_hold_pc", out_pc, 32'h400);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("two_pop_types", out_types, 7'h01);
    chk("two_pop_imm", out_imm, 0);
    chk("two_pop_pc", out_pc, 32'h404);
    chk("two_pop_in_ready", in_ready, 1);
    cyc();
    chk("two_empty", out_valid, 0);

    // continuous stream with simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_instr = 32'h00000013 | (32'(i) << 20);
      in_pc = 32'h200 + 32'(4 * i);
      cyc();
      chk($sformatf("s%0d_in_ready", i), in_ready, 1);
      chk($sformatf("s%0d_pc", i), out_pc, 32'h200 + 32'(4 * i));
      chk($sformatf("s%0d_imm", i), out_imm, 32'(i));
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_end", out_valid, 0);

    // flush while full with a new entry offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    cyc();
    in_pc = 32'h304;
    cyc();
    chk("fl_full", in_ready, 0);
    in_pc = 32'h308; flush = 1'b1;
    cyc();
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_pc", out_pc, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("fl_absent", out_valid, 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h500;
    cyc();
    in_pc = 32'h504;
    cyc();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_cnt", illegal_cnt, 0);
    chk("ar_instr", out_instr, 0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("ar_after", out_valid, 0);

    // illegal counter saturation
    in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h600;
    for (int k = 1; k <= 300; k++) begin
      cyc();
      chk($sformatf("il%0d_flag", k), out_illegal, 1);
      chk($sformatf("il%0d_types", k), out_types, 0);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        chk($sformatf("il%0d_cnt", k), illegal_cnt, (k > 255) ? 255 : k);
    end
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("il_flush_cnt", illegal_cnt, 255);
    chk("il_flush_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
